nibble_serial_add_ctrl: RTL

//  Sequencer that performs one WIDTH-bit addition using a single 4-bit ripple

---
 rtl/nsa_pkg.sv | 30 +++
 rtl/four_bit_vedic_adder.sv | 27 ++
 rtl/nibble_serial_add_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encodings
//   state_t                : enumerated FSM state type built on those encodings
//   clog2                  : ceiling log2, used to size the nibble index
package nsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Ceiling log2 of v (returns 0 for v <= 1); elaboration-time only.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/four_bit_vedic_adder.sv
// Four-bit adder slice shared by the nibble-serial sequencer.
// Ports:
//   a, b  in  [3:0]  nibble operands
//   cin   in         carry in
//   s     out [3:0]  nibble sum
//   cout  out        carry out of bit 3
module four_bit_vedic_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  // Ripple chain of full adders, bit 0 first.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: one WIDTH-bit add per operation, computed
// LSB nibble first through a single 4-bit slice, one nibble per clock, with
// the carry registered between nibbles.
// Optional build macro: APPROX_LSB_EN -- when defined, the lowest
// APPROX_NIBBLES nibbles are a bitwise OR with carry out forced to 0.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, cin captured on acceptance
//   out_valid/out_ready result handshake; sum, cout held while out_valid=1
//   busy                high while the nibble loop is running
import nsa_pkg::*;

module nibble_serial_add_ctrl #(
  parameter int WIDTH          = 16,
  parameter int APPROX_NIBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (clog2(NIB) < 1) ? 1 : clog2(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] slice_s;
  logic       slice_c;
  logic [3:0] nib_sum;
  logic       nib_c;

  // Select the current nibble of the latched operands.
  always_comb begin
    a_nib = a_q[{idx, 2'b00} +: 4];
    b_nib = b_q[{idx, 2'b00} +: 4];
  end

  four_bit_vedic_adder u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

`ifdef APPROX_LSB_EN
  localparam logic [IW:0] APPROX_LIM = (IW+1)'(APPROX_NIBBLES);

  // Low nibbles bypass the slice; their zero carry also makes cin irrelevant.
  always_comb begin
    if ({1'b0, idx} < APPROX_LIM) begin
      nib_sum = a_nib | b_nib;
      nib_c   = 1'b0;
    end else begin
      nib_sum = slice_s;
      nib_c   = slice_c;
    end
  end
`else
  // Every nibble uses the exact slice result.
  always_comb begin
    nib_sum = slice_s;
    nib_c   = slice_c;
  end
`endif

  // Only out_ready feeds in_ready; in_valid never loops back into it.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);

  // Controller FSM with registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[{idx, 2'b00} +: 4] <= nib_sum;
          carry                  <= nib_c;
          if (idx == LAST_IDX) begin
            cout      <= nib_c;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Handoff and next acceptance may share this edge.
            if (in_valid) begin
              a_q   <= a;
              b_q   <= b;
              carry <= cin;
              idx   <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
